// File: rtl/ifetch_unit.sv
// Instruction fetch stage: issues reads at PC and delivers fetched words to IR.
// A held-instruction buffer absorbs a memory response that arrives while decode
// is stalled. Misaligned fetches park the unit in ERR until a redirect.
module ifetch_unit #(
  parameter logic [31:0] RESET_IR    = 32'h0000_0000,
  parameter bit          ALIGN_CHECK = 1'b1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] PC,
  input  logic        Stall,
  input  logic        Flush,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemReady,
  input  logic [31:0] IMemRData,
  output logic        PCWrite,
  output logic [31:0] IR,
  output logic        IRValid,
  output logic [31:0] IR_PC,
  output logic [31:0] IR_PC4,
  output logic        AddrErr,
  output logic [31:0] FetchCnt
);

  typedef enum logic [1:0] {FETCH, HOLD, ERR} state_t;

  state_t      state;
  logic [31:0] buffer;
  logic [31:0] buf_pc;
  logic        misaligned;

  assign misaligned = ALIGN_CHECK && (PC[1:0] != 2'b00);
  assign IMemAddr   = PC;

  // Request and PC-advance strobes; a redirect always advances the PC.
  always_comb begin
    IMemReq = 1'b0;
    PCWrite = 1'b0;
    if (!Reset) begin
      if (Flush) begin
        PCWrite = 1'b1;
      end else if (state == FETCH && !misaligned) begin
        IMemReq = 1'b1;
        PCWrite = IMemReady;
      end
    end
  end

  // Fetch state machine with registered instruction outputs.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= FETCH;
      IR       <= RESET_IR;
      IRValid  <= 1'b0;
      IR_PC    <= 32'd0;
      IR_PC4   <= 32'd4;
      buffer   <= 32'd0;
      buf_pc   <= 32'd0;
      AddrErr  <= 1'b0;
      FetchCnt <= 32'd0;
    end else if (Flush) begin
      state   <= FETCH;
      IR      <= RESET_IR;
      IRValid <= 1'b0;
      buffer  <= 32'd0;
      buf_pc  <= 32'd0;
      AddrErr <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (misaligned) begin
            AddrErr <= 1'b1;
            IRValid <= 1'b0;
            state   <= ERR;
          end else if (IMemReady) begin
            if (Stall) begin
              buffer <= IMemRData;
              buf_pc <= PC;
              state  <= HOLD;
            end else begin
              IR       <= IMemRData;
              IR_PC    <= PC;
              IR_PC4   <= PC + 32'd4;
              IRValid  <= 1'b1;
              FetchCnt <= FetchCnt + 32'd1;
            end
          end
        end
        HOLD: begin
          if (!Stall) begin
            IR       <= buffer;
            IR_PC    <= buf_pc;
            IR_PC4   <= buf_pc + 32'd4;
            IRValid  <= 1'b1;
            FetchCnt <= FetchCnt + 32'd1;
            state    <= FETCH;
          end
        end
        ERR: begin
          state <= ERR;
        end
        default: begin
          state <= FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Randomized scoreboard bench for ifetch_unit.
module tb_ifetch_unit;

  localparam logic [31:0] RIR = 32'h0000_0013;

  logic        Clk, Reset, Stall, Flush, IMemReady;
  logic [31:0] PC, IMemRData;
  logic        IMemReq, PCWrite, IRValid, AddrErr;
  logic [31:0] IMemAddr, IR, IR_PC, IR_PC4, FetchCnt;

  ifetch_unit #(.RESET_IR(RIR), .ALIGN_CHECK(1'b1)) dut (
    .Clk(Clk), .Reset(Reset), .PC(PC), .Stall(Stall), .Flush(Flush),
    .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemReady(IMemReady),
    .IMemRData(IMemRData), .PCWrite(PCWrite), .IR(IR), .IRValid(IRValid),
    .IR_PC(IR_PC), .IR_PC4(IR_PC4), .AddrErr(AddrErr), .FetchCnt(FetchCnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct packed { logic [31:0] ir; logic [31:0] pc; logic [31:0] cnt; } dlv_t;
  typedef struct packed { logic irvalid; logic addrerr; logic chk_ir; logic [31:0] ir; } stat_t;

  dlv_t  dq[$];
  stat_t sq[$];

  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;
  logic [31:0] last_cnt;

  // Reference view: the instruction a word address holds, and the transaction-level state
  // of the fetch stage (idle/fetching, one word parked for decode, or faulted).
  int          m_mode;        // 0 fetching, 1 word parked, 2 faulted
  logic [31:0] m_park, m_park_pc, m_cnt, m_ir, pc, pc_nxt;
  logic        m_valid, m_err;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_valid = 1'b0; m_err = 1'b0; m_ir = RIR; m_cnt = 32'd0;
    m_park = 32'd0; m_park_pc = 32'd0;
  endtask

  // Randomize this cycle's inputs (called just after a rising edge).
  task automatic drive();
    pc = pc_nxt;
    if (m_mode == 0 && $urandom_range(0, 39) == 0) pc = pc | 32'd2;
    Stall     = ($urandom_range(0, 9) < 3);
    Flush     = (m_mode == 2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 24) == 0);
    IMemReady = ($urandom_range(0, 9) < 6);
    PC        = pc;
    IMemRData = IMemReady ? memf(pc) : $urandom;
  endtask

  // Check combinational outputs and predict the effect of the coming edge.
  task automatic step();
    logic mis;
    logic exp_req, exp_pcw;
    mis = (pc[1:0] != 2'b00);
    pc_nxt = pc;
    exp_req = 1'b0;
    exp_pcw = 1'b0;
    if (Flush) begin
      exp_pcw = 1'b1;
      m_mode = 0; m_valid = 1'b0; m_err = 1'b0; m_ir = RIR;
      pc_nxt = {$urandom_range(0, 1023), 2'b00};
      if ($urandom_range(0, 9) == 0) pc_nxt = pc_nxt + 32'd1;
    end else if (m_mode == 0) begin
      if (mis) begin
        m_mode = 2; m_err = 1'b1; m_valid = 1'b0;
      end else begin
        exp_req = 1'b1;
        if (IMemReady) begin
          exp_pcw = 1'b1;
          pc_nxt = pc + 32'd4;
          if (Stall) begin
            m_mode = 1; m_park = memf(pc); m_park_pc = pc;
          end else begin
            m_cnt = m_cnt + 32'd1; m_valid = 1'b1; m_ir = memf(pc);
            dq.push_back('{ir: memf(pc), pc: pc, cnt: m_cnt});
          end
        end
      end
    end else if (m_mode == 1) begin
      if (!Stall) begin
        m_cnt = m_cnt + 32'd1; m_valid = 1'b1; m_ir = m_park; m_mode = 0;
        dq.push_back('{ir: m_park, pc: m_park_pc, cnt: m_cnt});
      end
    end
    chk("imemreq", 32'(IMemReq), 32'(exp_req));
    chk("pcwrite", 32'(PCWrite), 32'(exp_pcw));
    chk("imemaddr", IMemAddr, pc);
    sq.push_back('{irvalid: m_valid, addrerr: m_err, chk_ir: Flush, ir: RIR});
  endtask

  // Monitor: compares registered outputs shortly after each edge.
  initial begin
    stat_t s;
    dlv_t d;
    forever begin
      @(posedge Clk);
      #2;
      if (mon_en) begin
        if (sq.size() == 0) begin
          chk("status_queue_empty", 32'd1, 32'd0);
        end else begin
          s = sq.pop_front();
          chk("irvalid", 32'(IRValid), 32'(s.irvalid));
          chk("addrerr", 32'(AddrErr), 32'(s.addrerr));
          if (s.chk_ir) chk("ir_after_flush", IR, s.ir);
        end
        if (FetchCnt !== last_cnt) begin
          if (dq.size() == 0) begin
            chk("unexpected_delivery", FetchCnt, last_cnt);
          end else begin
            d = dq.pop_front();
            chk("ir", IR, d.ir);
            chk("ir_pc", IR_PC, d.pc);
            chk("ir_pc4", IR_PC4, d.pc + 32'd4);
            chk("fetchcnt", FetchCnt, d.cnt);
          end
          last_cnt = FetchCnt;
        end
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ir"}, IR, RIR);
    chk({tag, "_irvalid"}, 32'(IRValid), 32'd0);
    chk({tag, "_ir_pc"}, IR_PC, 32'd0);
    chk({tag, "_addrerr"}, 32'(AddrErr), 32'd0);
    chk({tag, "_fetchcnt"}, FetchCnt, 32'd0);
    chk({tag, "_imemreq"}, 32'(IMemReq), 32'd0);
    chk({tag, "_pcwrite"}, 32'(PCWrite), 32'd0);
  endtask

  // Reset pulse while a read is waiting; a late ready during reset must be ignored.
  task automatic mid_reset();
    @(posedge Clk);
    #1;
    mon_en = 1'b0;
    Flush = 1'b0; Stall = 1'b0; IMemReady = 1'b0; PC = pc; IMemRData = $urandom;
    #2;
    Reset = 1'b1;
    #1;
    check_reset_vals("midreset");
    #1;
    IMemReady = 1'b1; IMemRData = memf(pc);
    dq.delete(); sq.delete();
    model_reset();
    last_cnt = 32'd0;
    @(posedge Clk);
    #1;
    chk("reset_hold_fetchcnt", FetchCnt, 32'd0);
    chk("reset_hold_ir", IR, RIR);
    Reset = 1'b0; IMemReady = 1'b0; Stall = 1'b0; Flush = 1'b0;
    pc_nxt = pc;
    #4;
    step();
    mon_en = 1'b1;
  endtask

  initial begin
    Reset = 1'b1; Stall = 1'b0; Flush = 1'b0; IMemReady = 1'b0;
    PC = 32'd0; IMemRData = 32'd0;
    pc = 32'd0; pc_nxt = 32'd0; last_cnt = 32'd0;
    model_reset();
    #2;
    check_reset_vals("por");
    @(posedge Clk);
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    // Zero-wait back-to-back fetches from address 0.
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin @(posedge Clk); #1; end
      pc = pc_nxt; PC = pc; Stall = 1'b0; Flush = 1'b0;
      IMemReady = 1'b1; IMemRData = memf(pc);
      #4;
      step();
      if (i == 0) mon_en = 1'b1;
    end
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc % 900 == 450 && m_mode == 0 && !Flush) begin
        mid_reset();
      end else begin
        @(posedge Clk);
        #1;
        drive();
        #4;
        step();
      end
    end
    @(posedge Clk);
    #3;
    chk("pending_deliveries", 32'(dq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
